lru_arbiter: RTL

- Shares one resource among LENGTH requesters.
- On every arbitration, grants the least-recently-granted requester that is currently requesting.
- Holds the grant until the owner signals done, then re-arbitrates, with back-to-back grants allowed.
- Sits in front of shared datapath resources such as a cache refill port or a memory port; recency ordering is kept by a dedicated sub-module.

---
 rtl/lru_arb_pkg.sv | 15 +
 rtl/lru_order.sv | 56 +++++
 rtl/lru_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/lru_arb_pkg.sv
// Shared types and helpers for the LRU arbiter: FSM state type, index width, one-hot decode.
package lru_arb_pkg;

    localparam int DEFAULT_LENGTH = 8;
    localparam int MAX_LENGTH     = 64;
    localparam int IDX_W          = $clog2(DEFAULT_LENGTH);

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    // Callers size the result to their own LENGTH with a cast.
    function automatic logic [MAX_LENGTH-1:0] onehot(input logic [31:0] idx);
        return MAX_LENGTH'(1) << idx;
    endfunction

endpackage

// File: rtl/lru_order.sv
// Recency list for the LRU arbiter: order[0] is least recently granted, order[LENGTH-1] most recent.
module lru_order
    import lru_arb_pkg::*;
#(
    parameter int LENGTH = DEFAULT_LENGTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LENGTH-1:0]         req,
    input  logic                      update,
    input  logic [$clog2(LENGTH)-1:0] update_idx,
    output logic [$clog2(LENGTH)-1:0] winner,
    output logic                      found
);

    localparam int IW = $clog2(LENGTH);

    logic [IW-1:0] order_q [LENGTH];
    logic [IW-1:0] order_d [LENGTH];

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin : next_order
        logic shifting;
        shifting = 1'b0;
        order_d  = order_q;
        if (update) begin
            for (int k = 0; k < LENGTH - 1; k++) begin
                if (order_q[k] == update_idx) shifting = 1'b1;
                if (shifting) order_d[k] = order_q[k + 1];
            end
            order_d[LENGTH - 1] = update_idx;
        end
    end

    always_comb begin : first_requester
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < LENGTH; k++) begin
            if (!found && req[order_q[k]]) begin
                winner = order_q[k];
                found  = 1'b1;
            end
        end
    end

    // NOTE: the list must be reset to identity (unlike a data memory) because it has to stay a
    // permutation; sequential state is always written with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LENGTH; k++) order_q[k] <= IW'(k);
        end else begin
            order_q <= order_d;
        end
    end

endmodule

// File: rtl/lru_arbiter.sv
// Least-recently-granted arbiter with grant hold until done.
// Optional forced release after MAX_HOLD cycles when LRU_ARB_TIMEOUT_EN is defined.
module lru_arbiter
    import lru_arb_pkg::*;
#(
    parameter int LENGTH   = DEFAULT_LENGTH,
    parameter int MAX_HOLD = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LENGTH-1:0]         req,
    input  logic                      done,
    output logic [LENGTH-1:0]         gnt,
    output logic [$clog2(LENGTH)-1:0] gnt_idx,
    output logic                      gnt_valid,
    output logic                      timeout
);

    localparam int IW = $clog2(LENGTH);

    if (LENGTH < 2 || (LENGTH & (LENGTH - 1)) != 0 || LENGTH > MAX_LENGTH || MAX_HOLD < 2) begin : g_bad_param
        $error("lru_arbiter: LENGTH must be a power of two in 2..64 and MAX_HOLD >= 2");
    end

    // Assert asynchronously, release two clocks after rst rises.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    logic [IW-1:0] winner;
    logic          found;
    logic          update;

    lru_order #(.LENGTH(LENGTH)) u_order (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .update     (update),
        .update_idx (winner),
        .winner     (winner),
        .found      (found)
    );

    arb_state_t        state_q, state_d;
    logic [LENGTH-1:0] gnt_q, gnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              hit;
    logic              release_w;

`ifdef LRU_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);

    logic [HOLD_W-1:0] hold_q, hold_d;

    assign hit = (state_q == ARB_BUSY) && !done && (hold_q == HOLD_W'(MAX_HOLD - 1));

    // Any release or new grant restarts the count; only an uninterrupted hold advances it.
    always_comb begin
        hold_d = '0;
        if (state_q == ARB_BUSY && !release_w) hold_d = hold_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_q <= '0;
        else        hold_q <= hold_d;
    end

    assign timeout = hit;
`else
    assign hit     = 1'b0;
    assign timeout = 1'b0;
`endif

    assign release_w = done | hit;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        update  = 1'b0;
        if (state_q == ARB_IDLE || release_w) begin
            if (found) begin
                state_d = ARB_BUSY;
                gnt_d   = LENGTH'(onehot(32'(winner)));
                idx_d   = winner;
                update  = 1'b1;
            end else begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                idx_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == ARB_BUSY);

endmodule
